// File: rtl/imm_encode.sv
// Inverse immediate extender: encodes a 32-bit value into the 24-bit Instr immediate field.
// Optional build macro FLOAT_IMM_EN adds a float input that limits rotated encodes to r=0.
module imm_encode #(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ImmSrc,
`ifdef FLOAT_IMM_EN
  input  logic        float,
`endif
  input  logic [31:0] Value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] Instr
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [1:0] SRC_ROT   = 2'b00;
  localparam logic [1:0] SRC_IMM12 = 2'b01;
  localparam logic [1:0] SRC_BR    = 2'b10;
  localparam logic [3:0] LAST_ROT  = 4'(ROT_STEPS - 1);

  state_t      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic [1:0]  src_q, src_d;
  logic        float_q, float_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [23:0] instr_q, instr_d;

  logic        float_in;
  logic [63:0] rot_dbl;
  logic [31:0] rot_t;
  logic        res_ok;
  logic [23:0] res_instr;

`ifdef FLOAT_IMM_EN
  assign float_in = float;
`else
  assign float_in = 1'b0;
`endif

  // Upper half of the doubled word shifted left is a rotate-left by 2r.
  assign rot_dbl = {value_q, value_q} << {rot_q, 1'b0};
  assign rot_t   = rot_dbl[63:32];

  // Single-cycle encodes (imm12, branch, reserved, float imm8) resolve from the latched operands.
  always_comb begin
    res_ok    = 1'b0;
    res_instr = '0;
    case (src_q)
      SRC_ROT: begin
        res_ok    = float_q && (value_q[31:8] == '0);
        res_instr = res_ok ? {16'b0, value_q[7:0]} : '0;
      end
      SRC_IMM12: begin
        res_ok    = (value_q[31:12] == '0);
        res_instr = res_ok ? {12'b0, value_q[11:0]} : '0;
      end
      SRC_BR: begin
        res_ok    = (value_q[1:0] == 2'b00) && (value_q[31:25] == {7{value_q[25]}});
        res_instr = res_ok ? value_q[25:2] : '0;
      end
      default: begin
        res_ok    = 1'b0;
        res_instr = '0;
      end
    endcase
  end

  // NOTE: every *_d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    value_d = value_q;
    src_d   = src_q;
    float_d = float_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    instr_d = instr_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = res_ok;
          instr_d = res_instr;
        end else if (start) begin
          value_d = Value;
          src_d   = ImmSrc;
          float_d = float_in;
          ok_d    = 1'b0;
          instr_d = '0;
          rot_d   = '0;
          busy_d  = 1'b1;
          if (ImmSrc == SRC_ROT && !float_in) state_d = SEARCH;
          else                                pend_d  = 1'b1;
        end
      end
      SEARCH: begin
        if (rot_t[31:8] == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = 1'b1;
          instr_d = {12'b0, rot_q, rot_t[7:0]};
        end else if (rot_q == LAST_ROT) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          instr_d = '0;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rot_q   <= '0;
      value_q <= '0;
      src_q   <= '0;
      float_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      value_q <= value_d;
      src_q   <= src_d;
      float_q <= float_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      instr_q <= instr_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ok    = ok_q;
  assign Instr = instr_q;

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: expected results queued at start, checked when done pulses.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  ImmSrc;
  logic [31:0] Value;
  logic        flt;
  logic        busy, done, ok;
  logic [23:0] Instr;

  imm_encode #(.ROT_STEPS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ImmSrc (ImmSrc),
`ifdef FLOAT_IMM_EN
    .float  (flt),
`endif
    .Value  (Value),
    .busy   (busy),
    .done   (done),
    .ok     (ok),
    .Instr  (Instr)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int          done_edge;
    logic        ok;
    logic [23:0] instr;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: done=1 at edge %0d, required no pending request", edges);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (edges !== mon_e.done_edge) begin
          n_bad++;
          $display("FAIL %s latency: done at edge %0d, required edge %0d", mon_e.name, edges, mon_e.done_edge);
        end
        n_cmp++;
        if (ok !== mon_e.ok) begin
          n_bad++;
          $display("FAIL %s ok: got %b, required %b", mon_e.name, ok, mon_e.ok);
        end
        n_cmp++;
        if (Instr !== mon_e.instr) begin
          n_bad++;
          $display("FAIL %s instr: got %06h, required %06h", mon_e.name, Instr, mon_e.instr);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // lat = edges from the accepting edge k to the done edge.
  task automatic push_exp(input string nm, input logic eok, input logic [23:0] einstr, input int lat);
    exp_t e;
    e.done_edge = edges + 1 + lat;
    e.ok        = eok;
    e.instr     = einstr;
    e.name      = nm;
    sb.push_back(e);
  endtask

  task automatic issue(input string nm, input logic [1:0] src, input logic [31:0] val, input logic fl,
                       input logic eok, input logic [23:0] einstr, input int lat);
    @(negedge clk);
    ImmSrc = src; Value = val; flt = fl; start = 1'b1;
    push_exp(nm, eok, einstr, lat);
    @(negedge clk);
    start = 1'b0; ImmSrc = ~src; Value = ~val; flt = ~fl;
    drain();
  endtask

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if ({busy, done, ok, Instr} !== 27'd0) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b ok=%b Instr=%06h, required all 0", nm, busy, done, ok, Instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ImmSrc = 2'b00; Value = '0; flt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_values");
    reset = 1'b0;
  endtask

  task automatic test_rotated();
    issue("rot_ff",       2'b00, 32'h0000_00FF, 1'b0, 1'b1, 24'h0000FF, 1);
    issue("rot_zero",     2'b00, 32'h0000_0000, 1'b0, 1'b1, 24'h000000, 1);
    issue("rot_ff000000", 2'b00, 32'hFF00_0000, 1'b0, 1'b1, 24'h0004FF, 5);
    issue("rot_f000000f", 2'b00, 32'hF000_000F, 1'b0, 1'b1, 24'h0002FF, 3);
    issue("rot_3f0",      2'b00, 32'h0000_03F0, 1'b0, 1'b1, 24'h000E3F, 15);
    issue("rot_3fc",      2'b00, 32'h0000_03FC, 1'b0, 1'b1, 24'h000FFF, 16);
  endtask

  // Failing search: busy must stay high throughout and stray starts must not disturb it.
  task automatic test_fail_busy();
    @(negedge clk);
    ImmSrc = 2'b00; Value = 32'h0000_0101; flt = 1'b0; start = 1'b1;
    push_exp("rot_fail_101", 1'b0, 24'h000000, 16);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      start  = (j == 2 || j == 10);
      ImmSrc = 2'b01;
      Value  = 32'h0000_0ABC;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_during_search: busy=%b after edge k+%0d, required 1", busy, j);
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_fail: busy=%b, required 0", busy);
    end
    drain();
  endtask

  task automatic test_imm12();
    issue("imm12_abc",   2'b01, 32'h0000_0ABC, 1'b0, 1'b1, 24'h000ABC, 1);
    issue("imm12_fff",   2'b01, 32'h0000_0FFF, 1'b0, 1'b1, 24'h000FFF, 1);
    issue("imm12_1000",  2'b01, 32'h0000_1000, 1'b0, 1'b0, 24'h000000, 1);
    issue("imm12_neg",   2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 24'h000000, 1);
  endtask

  task automatic test_branch();
    issue("br_m8",       2'b10, 32'hFFFF_FFF8, 1'b0, 1'b1, 24'hFFFFFE, 1);
    issue("br_misalign", 2'b10, 32'h0000_0006, 1'b0, 1'b0, 24'h000000, 1);
    issue("br_overflow", 2'b10, 32'h0200_0000, 1'b0, 1'b0, 24'h000000, 1);
    issue("br_maxpos",   2'b10, 32'h01FF_FFFC, 1'b0, 1'b1, 24'h7FFFFF, 1);
    issue("br_minneg",   2'b10, 32'hFE00_0000, 1'b0, 1'b1, 24'h800000, 1);
    issue("reserved",    2'b11, 32'h0000_0000, 1'b0, 1'b0, 24'h000000, 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ImmSrc = 2'b00; Value = 32'hFF00_0000; flt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_search");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_idle_outputs("after_reset_quiet");
    issue("post_reset_ff", 2'b00, 32'h0000_00FF, 1'b0, 1'b1, 24'h0000FF, 1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ImmSrc = 2'b01; Value = 32'h0000_0ABC; flt = 1'b0; start = 1'b1;
    push_exp("b2b_first", 1'b1, 24'h000ABC, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done_visible: done=%b, required 1", done);
    end
    ImmSrc = 2'b00; Value = 32'hFF00_0000; start = 1'b1;
    push_exp("b2b_second", 1'b1, 24'h0004FF, 5);
    @(negedge clk);
    start = 1'b0; Value = 32'h0000_0001;
    n_cmp++;
    if ({ok, Instr} !== 25'd0) begin
      n_bad++;
      $display("FAIL b2b_clear: ok=%b Instr=%06h, required 0/000000", ok, Instr);
    end
    drain();
  endtask

`ifdef FLOAT_IMM_EN
  task automatic test_float();
    issue("float_ff000000", 2'b00, 32'hFF00_0000, 1'b1, 1'b0, 24'h000000, 1);
    issue("float_7f",       2'b00, 32'h0000_007F, 1'b1, 1'b1, 24'h00007F, 1);
    issue("nofloat_ff0000", 2'b00, 32'hFF00_0000, 1'b0, 1'b1, 24'h0004FF, 5);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rotated();
    test_fail_busy();
    test_imm12();
    test_branch();
    test_reset_mid();
    test_back_to_back();
`ifdef FLOAT_IMM_EN
    test_float();
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
